// File: rtl/spi_reg_tx.sv
// SPI mode-0 frame transmitter: sends up to DATA_W bits MSB-first with csb framing and a guard gap.
// Optional abort input enabled by defining SPI_REG_TX_ABORT_EN.
module spi_reg_tx #(
  parameter int DATA_W = 48,
  parameter int DIV    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [6:0]        i_len,
`ifdef SPI_REG_TX_ABORT_EN
  input  logic              i_abort,
`endif
  output logic              o_csb,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_done,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [6:0] MAX_LEN = 7'(DATA_W);

  // Handshake: a request is taken on a rising edge where i_valid && o_ready;
  // i_valid may be held across frames, o_ready is high only while IDLE.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [6:0]         bits_left;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  aligned;
  logic [6:0]         eff_len;
  logic               cnt_end;
  logic               abort_hit;

  // Left-align the payload so bit L-1 sits at the MSB of the shift register.
  assign eff_len = (i_len > MAX_LEN) ? MAX_LEN : i_len;
  assign aligned = i_data << (MAX_LEN - eff_len);
  assign shifted = shreg << 1;
  assign cnt_end = (cnt == CNT_LAST);
  assign dbg_state = state;

`ifdef SPI_REG_TX_ABORT_EN
  assign abort_hit = i_abort && (state inside {S_SETUP, S_HIGH, S_LOW, S_HOLD});
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bits_left <= '0;
      shreg     <= '0;
      o_ready   <= 1'b0;
      o_csb     <= 1'b1;
      o_sclk    <= 1'b0;
      o_mosi    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (abort_hit) begin
        state  <= S_GAP;
        cnt    <= '0;
        o_csb  <= 1'b1;
        o_sclk <= 1'b0;
        o_mosi <= 1'b0;
      end else begin
        if (state != S_IDLE) cnt <= cnt_end ? '0 : cnt + 1'b1;
        case (state)
          S_IDLE: begin
            if (i_valid && o_ready) begin
              o_ready <= 1'b0;
              if (eff_len == 7'd0) begin
                o_done <= 1'b1;
              end else begin
                state     <= S_SETUP;
                cnt       <= '0;
                bits_left <= eff_len;
                shreg     <= aligned;
                o_csb     <= 1'b0;
                o_mosi    <= aligned[DATA_W-1];
              end
            end else begin
              o_ready <= 1'b1;
            end
          end
          S_SETUP: begin
            if (cnt_end) begin
              state  <= S_HIGH;
              o_sclk <= 1'b1;
            end
          end
          S_HIGH: begin
            if (cnt_end) begin
              o_sclk <= 1'b0;
              if (bits_left > 7'd1) begin
                state     <= S_LOW;
                bits_left <= bits_left - 7'd1;
                shreg     <= shifted;
                o_mosi    <= shifted[DATA_W-1];
              end else begin
                state <= S_HOLD;
              end
            end
          end
          S_LOW: begin
            if (cnt_end) begin
              state  <= S_HIGH;
              o_sclk <= 1'b1;
            end
          end
          S_HOLD: begin
            if (cnt_end) begin
              state  <= S_GAP;
              o_csb  <= 1'b1;
              o_mosi <= 1'b0;
            end
          end
          S_GAP: begin
            if (cnt_end) begin
              state   <= S_IDLE;
              o_done  <= 1'b1;
              o_ready <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_tx.sv
// Bench for spi_reg_tx: a DIV=2 and a DIV=1 instance, a negedge monitor that records
// frames, and a frame-level reference (bit order, csb length, done timing).
module tb_spi_reg_tx;

  localparam int DW = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          drv_valid;
  logic [DW-1:0] drv_data;
  logic [6:0]    drv_len;
  logic          sel;
`ifdef SPI_REG_TX_ABORT_EN
  logic          drv_abort;
`endif

  logic ready2, csb2, sclk2, mosi2, done2;
  logic ready1, csb1, sclk1, mosi1, done1;
  logic [2:0] state2, state1;
  logic valid2, valid1;
  logic rdy, csb, sclk, mosi, done;

  assign valid2 = drv_valid & ~sel;
  assign valid1 = drv_valid & sel;
  assign rdy  = sel ? ready1 : ready2;
  assign csb  = sel ? csb1   : csb2;
  assign sclk = sel ? sclk1  : sclk2;
  assign mosi = sel ? mosi1  : mosi2;
  assign done = sel ? done1  : done2;

  spi_reg_tx #(.DATA_W(DW), .DIV(2)) u_d2 (
    .clk(clk), .reset_n(reset_n), .i_valid(valid2), .o_ready(ready2),
    .i_data(drv_data), .i_len(drv_len),
`ifdef SPI_REG_TX_ABORT_EN
    .i_abort(drv_abort & ~sel),
`endif
    .o_csb(csb2), .o_sclk(sclk2), .o_mosi(mosi2), .o_done(done2), .dbg_state(state2)
  );

  spi_reg_tx #(.DATA_W(DW), .DIV(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .i_valid(valid1), .o_ready(ready1),
    .i_data(drv_data), .i_len(drv_len),
`ifdef SPI_REG_TX_ABORT_EN
    .i_abort(drv_abort & sel),
`endif
    .o_csb(csb1), .o_sclk(sclk1), .o_mosi(mosi1), .o_done(done1), .dbg_state(state1)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Monitor state
  int   cyc = 0;
  bit   mon_en = 0;
  logic prev_csb, prev_sclk;
  int   cur_low = 0, cur_high = 0, idle_bad = 0;
  logic bits_q[$];
  int   low_q[$], high_q[$], rise_q[$], done_q[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      if (csb === 1'b0) begin
        if (prev_csb === 1'b1) high_q.push_back(cur_high);
        cur_high = 0;
        cur_low++;
      end else begin
        if (prev_csb === 1'b0) begin
          low_q.push_back(cur_low);
          rise_q.push_back(cyc);
        end
        cur_low = 0;
        cur_high++;
      end
      if (sclk === 1'b1 && prev_sclk === 1'b0 && csb === 1'b0) bits_q.push_back(mosi);
      if (done === 1'b1) done_q.push_back(cyc);
      if (csb !== 1'b0 && (sclk !== 1'b0 || mosi !== 1'b0)) idle_bad++;
    end
    prev_csb  = csb;
    prev_sclk = sclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bits_q.delete(); low_q.delete(); high_q.delete(); rise_q.delete(); done_q.delete();
    idle_bad = 0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (rdy !== 1'b1 && k < 400) begin step(); k++; end
    if (k >= 400) check("ready_timeout", {63'd0, rdy}, 64'd1);
  endtask

  task automatic wait_done_n(input int n, input int limit);
    int k = 0;
    while (done_q.size() < n && k < limit) begin step(); k++; end
    if (k >= limit) check("done_timeout", 64'(done_q.size()), 64'(n));
  endtask

  task automatic wait_bits(input int n);
    int k = 0;
    while (bits_q.size() < n && k < 400) begin step(); k++; end
    if (k >= 400) check("bits_timeout", 64'(bits_q.size()), 64'(n));
  endtask

  task automatic start(input logic [DW-1:0] data, input logic [6:0] len);
    wait_ready();
    drv_data  = data;
    drv_len   = len;
    drv_valid = 1'b1;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    drv_data  = {$urandom, $urandom};
    drv_len   = 7'($urandom);
  endtask

  function automatic logic [63:0] pack_bits();
    logic [63:0] v = '0;
    foreach (bits_q[i]) v = {v[62:0], bits_q[i]};
    return v;
  endfunction

  // Reference: L = min(len, DW); bits L-1..0 of data appear in order;
  // csb low DIV*(2L+1); done DIV cycles after csb rises; L=0 -> done next cycle, no csb.
  task automatic run_frame(input string tag, input logic [DW-1:0] data, input int len);
    int div = sel ? 1 : 2;
    int l = (len > DW) ? DW : len;
    logic [63:0] exp_bits;
    clear_mon();
    start(data, 7'(len));
    if (l == 0) begin
      step();
      check({tag, "_z_done"}, {63'd0, done}, 64'd1);
      check({tag, "_z_rdy"}, {63'd0, rdy}, 64'd0);
      step();
      check({tag, "_z_done2"}, {63'd0, done}, 64'd0);
      check({tag, "_z_rdy2"}, {63'd0, rdy}, 64'd1);
      check({tag, "_z_nocsb"}, 64'(low_q.size() + bits_q.size()), 64'd0);
    end else begin
      exp_bits = 64'(data) & ((64'd1 << l) - 64'd1);
      wait_done_n(1, div * (2 * l + 1) + 4 * div + 20);
      check({tag, "_nbits"}, 64'(bits_q.size()), 64'(l));
      check({tag, "_bits"}, pack_bits(), exp_bits);
      check({tag, "_lowlen"}, (low_q.size() == 1) ? 64'(low_q[0]) : 64'hdead, 64'(div * (2 * l + 1)));
      check({tag, "_donedly"}, (rise_q.size() == 1 && done_q.size() == 1) ? 64'(done_q[0] - rise_q[0]) : 64'hdead, 64'(div));
      check({tag, "_rdy_at_done"}, {63'd0, rdy}, 64'd1);
      step();
      check({tag, "_done_pulse"}, 64'(done_q.size()), 64'd1);
      check({tag, "_idle_quiet"}, 64'(idle_bad), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; drv_valid = 1'b0; drv_data = '0; drv_len = '0; sel = 1'b0;
`ifdef SPI_REG_TX_ABORT_EN
    drv_abort = 1'b0;
`endif
    repeat (3) step();
    check("rst_csb", {62'd0, csb2, csb1}, 64'd3);
    check("rst_sclk", {62'd0, sclk2, sclk1}, 64'd0);
    check("rst_mosi", {62'd0, mosi2, mosi1}, 64'd0);
    check("rst_done", {62'd0, done2, done1}, 64'd0);
    check("rst_ready", {62'd0, ready2, ready1}, 64'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step();
    check("rel_ready", {62'd0, ready2, ready1}, 64'd3);

    // Directed frames
    sel = 1'b0;
    run_frame("a5_div2", 48'hA5, 8);
    sel = 1'b1;
    run_frame("long_div1", 48'h800000000001, 48);
    sel = 1'b0;
    run_frame("zero_len", 48'hFFFF, 0);
    run_frame("len100_div2", {$urandom, $urandom}, 100);
    sel = 1'b1;
    run_frame("len1_div1", 48'h1, 1);

    // Back-to-back with i_valid held
    sel = 1'b0;
    clear_mon();
    wait_ready();
    drv_data = 48'h9; drv_len = 7'd4; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_data = 48'h6;
    begin
      int k = 0;
      step();
      while (rdy !== 1'b1 && k < 200) begin step(); k++; end
      if (k >= 200) check("b2b_ready_timeout", {63'd0, rdy}, 64'd1);
    end
    @(posedge clk); #1;
    drv_valid = 1'b0; drv_data = {$urandom, $urandom};
    wait_done_n(2, 200);
    check("b2b_nbits", 64'(bits_q.size()), 64'd8);
    check("b2b_bits", pack_bits(), 64'h96);
    check("b2b_gap", (high_q.size() > 0) ? 64'(high_q[high_q.size()-1]) : 64'hdead, 64'd3);
    check("b2b_low0", (low_q.size() == 2) ? 64'(low_q[0]) : 64'hdead, 64'd18);
    check("b2b_low1", (low_q.size() == 2) ? 64'(low_q[1]) : 64'hdead, 64'd18);

    // Randomized frames on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int n = 0; n < 6; n++)
        run_frame($sformatf("rnd_s%0d_%0d", s, n), {$urandom, $urandom}, int'($urandom_range(0, 70)));
    end

    // Reset during bit 3
    sel = 1'b0;
    clear_mon();
    start({$urandom, $urandom}, 7'd8);
    wait_bits(3);
    reset_n = 1'b0;
    step();
    check("mrst_csb", {63'd0, csb}, 64'd1);
    check("mrst_sclk", {63'd0, sclk}, 64'd0);
    check("mrst_mosi", {63'd0, mosi}, 64'd0);
    check("mrst_ready", {63'd0, rdy}, 64'd0);
    step();
    reset_n = 1'b1;
    step();
    check("mrst_ready_rel", {63'd0, rdy}, 64'd1);
    repeat (30) step();
    check("mrst_no_done", 64'(done_q.size()), 64'd0);
    run_frame("post_rst", {$urandom, $urandom}, 12);

`ifdef SPI_REG_TX_ABORT_EN
    begin
      int abort_cyc;
      sel = 1'b0;
      clear_mon();
      start({$urandom, $urandom}, 7'd8);
      wait_bits(2);
      drv_abort = 1'b1;
      abort_cyc = cyc;
      step();
      drv_abort = 1'b0;
      check("abt_csb", {63'd0, csb}, 64'd1);
      check("abt_sclk", {63'd0, sclk}, 64'd0);
      check("abt_mosi", {63'd0, mosi}, 64'd0);
      wait_done_n(1, 50);
      check("abt_done_dly", (done_q.size() == 1) ? 64'(done_q[0] - abort_cyc) : 64'hdead, 64'd3);
      check("abt_nbits", 64'(bits_q.size()), 64'd2);
      step();
      run_frame("post_abt", {$urandom, $urandom}, 5);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
